music_sequencer: RTL and testbench

Beat-level sequencer for the buzzer tone datapath. Steps through a fixed song table of (tone code, duration) entries at one step per clk_4HZ tick (0.25 s). Supports start/stop/pause control and arbitration with the manual keypad. Its 14-bit one-hot `tone` output drives the existing tone-to-divider mux and the seven-segment display decoder in place of the hard-coded per-beat case table.

---
 rtl/music_pkg.sv | 22 ++
 rtl/music_song_rom.sv | 50 +++++
 rtl/music_sequencer.sv | 132 +++++++++++++
 tb/tb_music_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types, tone codes and the code-to-one-hot decode for the buzzer sequencer.
package music_pkg;

  localparam int TONE_W = 14;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] L1 = 4'd1, L2 = 4'd2, L3 = 4'd3, L4 = 4'd4;
  localparam logic [3:0] L5 = 4'd5, L6 = 4'd6, L7 = 4'd7;
  localparam logic [3:0] M1 = 4'd8, M2 = 4'd9, M3 = 4'd10, M4 = 4'd11;
  localparam logic [3:0] M5 = 4'd12, M6 = 4'd13, M7 = 4'd14;

  // Codes 1..14 select one bit; rest (0) and the unused code 15 are silence.
  function automatic logic [TONE_W-1:0] decode(input logic [3:0] c);
    logic [TONE_W-1:0] one;
    one = {{(TONE_W-1){1'b0}}, 1'b1};
    if (c >= 4'd1 && c <= 4'd14) return one << (c - 4'd1);
    return '0;
  endfunction

endpackage

// File: rtl/music_song_rom.sv
// Combinational song table: idx -> {code, dur}; out-of-range indices read as a one-tick rest.
module music_song_rom
  import music_pkg::*;
#(
  parameter int SONG_LEN = 61,
  parameter int DUR_W    = 3
) (
  input  logic [6:0]       idx,
  output logic [DUR_W+3:0] entry
);

  function automatic logic [DUR_W+3:0] ent(input logic [3:0] c, input int d);
    return {c, DUR_W'(d)};
  endfunction

  always_comb begin
    entry = ent(REST, 1);
    if (int'(idx) < SONG_LEN) begin
      case (idx)
        7'd0:  entry = ent(M3, 2);   7'd1:  entry = ent(M5, 1);   7'd2:  entry = ent(M1, 0);
        7'd3:  entry = ent(M2, 2);   7'd4:  entry = ent(M3, 1);
        7'd5:  entry = ent(M5, 1);   7'd6:  entry = ent(M6, 2);   7'd7:  entry = ent(REST, 1);
        7'd8:  entry = ent(M5, 1);   7'd9:  entry = ent(M3, 2);
        7'd10: entry = ent(M2, 1);   7'd11: entry = ent(M1, 1);   7'd12: entry = ent(L6, 2);
        7'd13: entry = ent(L5, 2);   7'd14: entry = ent(REST, 1);
        7'd15: entry = ent(L5, 1);   7'd16: entry = ent(L6, 1);   7'd17: entry = ent(M1, 2);
        7'd18: entry = ent(M2, 1);   7'd19: entry = ent(M3, 3);
        7'd20: entry = ent(M2, 1);   7'd21: entry = ent(M1, 1);   7'd22: entry = ent(L6, 2);
        7'd23: entry = ent(M1, 4);   7'd24: entry = ent(REST, 2);
        7'd25: entry = ent(M5, 1);   7'd26: entry = ent(M5, 1);   7'd27: entry = ent(M6, 2);
        7'd28: entry = ent(M5, 1);   7'd29: entry = ent(M3, 1);
        7'd30: entry = ent(M2, 2);   7'd31: entry = ent(M1, 1);   7'd32: entry = ent(M2, 1);
        7'd33: entry = ent(M3, 4);   7'd34: entry = ent(REST, 1);
        7'd35: entry = ent(L7, 1);   7'd36: entry = ent(M1, 1);   7'd37: entry = ent(M2, 2);
        7'd38: entry = ent(M4, 1);   7'd39: entry = ent(M3, 1);
        7'd40: entry = ent(M2, 2);   7'd41: entry = ent(M1, 2);   7'd42: entry = ent(L7, 1);
        7'd43: entry = ent(L6, 1);   7'd44: entry = ent(L5, 4);
        7'd45: entry = ent(REST, 1); 7'd46: entry = ent(M3, 1);   7'd47: entry = ent(M5, 1);
        7'd48: entry = ent(M7, 2);   7'd49: entry = ent(M6, 1);
        7'd50: entry = ent(M5, 1);   7'd51: entry = ent(M3, 2);   7'd52: entry = ent(M2, 1);
        7'd53: entry = ent(M1, 1);   7'd54: entry = ent(M2, 2);
        7'd55: entry = ent(M3, 2);   7'd56: entry = ent(M2, 1);   7'd57: entry = ent(M1, 1);
        7'd58: entry = ent(L6, 2);   7'd59: entry = ent(M1, 4);
        7'd60: entry = ent(REST, 2);
        default: entry = ent(REST, 1);
      endcase
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Beat sequencer with keypad arbitration. Define SEQ_LOOP_EN to loop the song instead of
// returning to IDLE after the last entry.
module music_sequencer
  import music_pkg::*;
#(
  parameter int SONG_LEN = 61,
  parameter int DUR_W    = 3
) (
  input  logic              clk_4HZ,
  input  logic              rst,
  input  logic              auto,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [TONE_W-1:0] Key,
  output logic [TONE_W-1:0] tone,
  output logic [6:0]        note_idx,
  output logic              busy,
  output logic              done
);

  localparam logic [6:0] LAST_IDX = 7'(SONG_LEN - 1);

  state_t           state;
  logic [DUR_W-1:0] dur_cnt;
  logic [6:0]       rom_idx;
  logic [DUR_W+3:0] entry;
  logic [3:0]       e_code;
  logic [DUR_W-1:0] e_dur;
  logic [DUR_W-1:0] e_cnt;
  logic             at_last;
  logic             key_ok;

  assign at_last = (note_idx >= LAST_IDX);
  assign key_ok  = (Key != '0) && ((Key & (Key - 14'd1)) == '0);
  assign e_code  = entry[DUR_W+3:DUR_W];
  assign e_dur   = entry[DUR_W-1:0];
  // Duration 0 plays like duration 1, so both start the count at zero.
  assign e_cnt   = (e_dur == '0) ? '0 : e_dur - DUR_W'(1);

  // The one ROM port looks ahead to whichever entry this tick may load.
  always_comb begin
    rom_idx = note_idx;
    if (state == PLAY && dur_cnt == '0) rom_idx = at_last ? 7'd0 : note_idx + 7'd1;
  end

  music_song_rom #(
    .SONG_LEN(SONG_LEN),
    .DUR_W   (DUR_W)
  ) u_rom (
    .idx  (rom_idx),
    .entry(entry)
  );

  always_ff @(posedge clk_4HZ or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tone     <= '0;
      note_idx <= '0;
      dur_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!auto) begin
        state    <= IDLE;
        note_idx <= '0;
        dur_cnt  <= '0;
        busy     <= 1'b0;
        tone     <= key_ok ? Key : '0;
      end else begin
        case (state)
          IDLE: begin
            tone <= '0;
            if (start && !stop) begin
              state    <= PLAY;
              busy     <= 1'b1;
              note_idx <= '0;
              tone     <= decode(e_code);
              dur_cnt  <= e_cnt;
            end
          end
          PLAY: begin
            if (stop) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tone     <= '0;
              note_idx <= '0;
              dur_cnt  <= '0;
            end else if (pause) begin
              state <= PAUSE;
              tone  <= '0;
            end else if (dur_cnt != '0) begin
              dur_cnt <= dur_cnt - DUR_W'(1);
            end else if (!at_last) begin
              note_idx <= rom_idx;
              tone     <= decode(e_code);
              dur_cnt  <= e_cnt;
            end else begin
              done <= 1'b1;
`ifdef SEQ_LOOP_EN
              note_idx <= '0;
              tone     <= decode(e_code);
              dur_cnt  <= e_cnt;
`else
              state    <= IDLE;
              busy     <= 1'b0;
              tone     <= '0;
              note_idx <= '0;
              dur_cnt  <= '0;
`endif
            end
          end
          PAUSE: begin
            if (stop) begin
              state    <= IDLE;
              busy     <= 1'b0;
              tone     <= '0;
              note_idx <= '0;
              dur_cnt  <= '0;
            end else if (!pause) begin
              state <= PLAY;
              tone  <= decode(e_code);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer using a 3-entry song: {M3,2}, {M5,1}, {M1,0}.
module tb_music_sequencer;

  logic        clk_4HZ;
  logic        rst;
  logic        auto;
  logic        start;
  logic        stop;
  logic        pause;
  logic [13:0] Key;
  logic [13:0] tone;
  logic [6:0]  note_idx;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [13:0] T_M3 = 14'h0200;
  localparam logic [13:0] T_M5 = 14'h0800;
  localparam logic [13:0] T_M1 = 14'h0080;

  music_sequencer #(
    .SONG_LEN(3),
    .DUR_W   (3)
  ) dut (
    .clk_4HZ (clk_4HZ),
    .rst     (rst),
    .auto    (auto),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .Key     (Key),
    .tone    (tone),
    .note_idx(note_idx),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk_4HZ = 1'b0;
    forever #5 clk_4HZ = ~clk_4HZ;
  end

  task automatic tick();
    @(posedge clk_4HZ);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; auto = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; Key = '0;
    #2;
    chk("rst_tone", tone, 0);
    chk("rst_idx", note_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #6 rst = 1'b1;
    tick();
    chk("idle_tone", tone, 0);
    chk("idle_busy", busy, 0);

    // Full song: start latency, durations, dur=0 entry, end of song.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e0_t1", tone, T_M3);
    chk("e0_busy", busy, 1);
    chk("e0_idx", note_idx, 0);
    tick();
    chk("e0_t2", tone, T_M3);
    tick();
    chk("e1_tone", tone, T_M5);
    chk("e1_idx", note_idx, 1);
    tick();
    chk("e2_tone", tone, T_M1);
    chk("e2_idx", note_idx, 2);
    chk("e2_done", done, 0);
    tick();
    chk("end_done", done, 1);
`ifdef SEQ_LOOP_EN
    chk("end_tone", tone, T_M3);
    chk("end_busy", busy, 1);
    chk("end_idx", note_idx, 0);
    tick();
    chk("loop_done", done, 0);
    chk("loop_tone", tone, T_M3);
`else
    chk("end_tone", tone, 0);
    chk("end_busy", busy, 0);
    chk("end_idx", note_idx, 0);
    tick();
    chk("post_done", done, 0);
    chk("post_tone", tone, 0);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stopped_tone", tone, 0);
    chk("stopped_busy", busy, 0);

    // Pause for three ticks with the first entry partly played.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("p_start", tone, T_M3);
    pause = 1'b1;
    tick();
    chk("p_hold1", tone, 0);
    chk("p_busy", busy, 1);
    tick();
    chk("p_hold2", tone, 0);
    tick();
    chk("p_hold3", tone, 0);
    chk("p_idx", note_idx, 0);
    pause = 1'b0;
    tick();
    chk("p_resume1", tone, T_M3);
    tick();
    chk("p_resume2", tone, T_M3);
    tick();
    chk("p_next", tone, T_M5);

    // stop beats pause and start.
    start = 1'b1; stop = 1'b1; pause = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    chk("prio_tone", tone, 0);
    chk("prio_busy", busy, 0);
    chk("prio_idx", note_idx, 0);
    tick();
    chk("prio_stay", tone, 0);

    // Asynchronous reset between edges while playing.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ar_play", tone, T_M3);
    #2 rst = 1'b0;
    #1;
    chk("ar_tone", tone, 0);
    chk("ar_busy", busy, 0);
    @(posedge clk_4HZ);
    #3 rst = 1'b1;
    tick();
    chk("ar_idle_tone", tone, 0);
    chk("ar_idle_busy", busy, 0);

    // Keypad takes over a running song.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("kp_song_idx", note_idx, 1);
    auto = 1'b0; Key = 14'h0010;
    tick();
    chk("kp_tone", tone, 14'h0010);
    chk("kp_idx", note_idx, 0);
    chk("kp_busy", busy, 0);
    Key = 14'h0011;
    tick();
    chk("kp_twohot", tone, 0);
    Key = 14'h2000;
    tick();
    chk("kp_top", tone, 14'h2000);
    Key = 14'h0000;
    tick();
    chk("kp_zero", tone, 0);
    Key = 14'h0001;
    tick();
    chk("kp_low", tone, 14'h0001);
    auto = 1'b1; Key = 14'h0010;
    tick();
    chk("kp_back_tone", tone, 0);
    chk("kp_back_busy", busy, 0);
    tick();
    chk("kp_back_stay", tone, 0);
    chk("kp_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
